// File: rtl/mf_taps_pkg.sv
// Matched-filter constants: 41-tap half-sine taps (round(32767*sin(pi*k/40)))
// plus default accumulator width and output shift.
package mf_taps_pkg;

  localparam int unsigned MF_NTAPS     = 41;
  localparam int unsigned MF_COEF_W    = 16;
  localparam int unsigned MF_ACC_W     = 40;
  localparam int unsigned MF_OUT_SHIFT = 20;

  localparam logic signed [MF_COEF_W-1:0] MF_COEFFS [MF_NTAPS] = '{
    16'sd0,     16'sd2571,  16'sd5126,  16'sd7649,  16'sd10126,
    16'sd12539, 16'sd14876, 16'sd17121, 16'sd19260, 16'sd21280,
    16'sd23170, 16'sd24916, 16'sd26509, 16'sd27938, 16'sd29196,
    16'sd30273, 16'sd31163, 16'sd31862, 16'sd32364, 16'sd32666,
    16'sd32767,
    16'sd32666, 16'sd32364, 16'sd31862, 16'sd31163, 16'sd30273,
    16'sd29196, 16'sd27938, 16'sd26509, 16'sd24916, 16'sd23170,
    16'sd21280, 16'sd19260, 16'sd17121, 16'sd14876, 16'sd12539,
    16'sd10126, 16'sd7649,  16'sd5126,  16'sd2571,  16'sd0
  };

endpackage

// File: rtl/mf_mac.sv
// Two-stage multiply-accumulate: registered product, then sign-extended
// accumulation. Clear wins over accumulate.
module mf_mac #(
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 16,
  parameter int unsigned ACC_W = 40
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int unsigned P_W = A_W + B_W;

  logic signed [P_W-1:0]   w_prod;
  logic signed [P_W-1:0]   r_prod;
  logic                    r_prod_vld;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod     = P_W'(i_a) * P_W'(i_b);
  assign w_prod_ext = ACC_W'(r_prod);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
    end else begin
      if (i_en) begin
        r_prod <= w_prod;
      end
      r_prod_vld <= i_en & ~i_clr;
      if (i_clr) begin
        r_acc <= '0;
      end else if (r_prod_vld) begin
        r_acc <= r_acc + w_prod_ext;
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mf_fir_serial.sv
// Time-multiplexed 41-tap matched filter: circular delay line, one MAC shared
// by every tap, rounded and saturated output held until accepted downstream.
module mf_fir_serial
  import mf_taps_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NTAPS     = MF_NTAPS,
  parameter int unsigned ACC_W     = MF_ACC_W,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned OUT_SHIFT = MF_OUT_SHIFT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] i_s_data,
  input  logic                     i_s_valid,
  output logic                     o_s_ready,
  output logic signed [OUT_W-1:0]  o_m_data,
  output logic                     o_m_valid,
  input  logic                     i_m_ready
);

  localparam int unsigned TAP_W = $clog2(NTAPS);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_K   = ACC_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_FLUSH, ST_OUT} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [TAP_W-1:0]          r_tap;
  logic                      r_flush;
  logic [TAP_W-1:0]          r_wptr;
  logic [TAP_W-1:0]          r_rd_idx;
  logic signed [DATA_W-1:0]  r_dline [NTAPS];
  logic                      r_s_ready;
  logic                      r_m_valid;
  logic signed [OUT_W-1:0]   r_m_data;

  logic                      w_accept;
  logic                      w_mac_en;
  logic                      w_load_out;
  logic                      w_out_done;
  logic signed [DATA_W-1:0]  w_tap_data;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [ACC_W-1:0]   w_acc;
  logic signed [ACC_W-1:0]   w_rnd;
  logic signed [ACC_W-1:0]   w_shr;
  logic signed [OUT_W-1:0]   w_sat;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_s_valid)          w_state_nxt = ST_MAC;
      ST_MAC:   if (r_tap == TAP_LAST)  w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_flush)            w_state_nxt = ST_OUT;
      ST_OUT:   if (i_m_ready)          w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    w_accept   = 1'b0;
    w_mac_en   = 1'b0;
    w_load_out = 1'b0;
    w_out_done = 1'b0;
    case (r_state)
      ST_IDLE:  w_accept   = i_s_valid;
      ST_MAC:   w_mac_en   = 1'b1;
      ST_FLUSH: w_load_out = r_flush;
      ST_OUT:   w_out_done = i_m_ready;
      default: ;
    endcase
  end

  // Tap sequencing; the read index walks backwards from the newest sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tap    <= '0;
      r_flush  <= 1'b0;
      r_wptr   <= '0;
      r_rd_idx <= '0;
    end else begin
      r_flush <= (r_state == ST_FLUSH) ? ~r_flush : 1'b0;
      if (w_accept) begin
        r_tap    <= '0;
        r_rd_idx <= r_wptr;
        r_wptr   <= (r_wptr == TAP_LAST) ? '0 : r_wptr + TAP_W'(1);
      end else if (w_mac_en) begin
        r_tap    <= r_tap + TAP_W'(1);
        r_rd_idx <= (r_rd_idx == '0) ? TAP_LAST : r_rd_idx - TAP_W'(1);
      end
    end
  end

  // Sample delay line
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        r_dline[i] <= '0;
      end
    end else if (w_accept) begin
      r_dline[r_wptr] <= i_s_data;
    end
  end

  assign w_tap_data = r_dline[r_rd_idx];
  assign w_coef     = COEF_W'(MF_COEFFS[r_tap]);

  mf_mac #(
    .A_W   (DATA_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_accept),
    .i_en  (w_mac_en),
    .i_a   (w_tap_data),
    .i_b   (w_coef),
    .o_acc (w_acc)
  );

  // Round half up, then clamp to the output range
  assign w_rnd = w_acc + RND_K;
  assign w_shr = w_rnd >>> OUT_SHIFT;

  always_comb begin
    w_sat = w_shr[OUT_W-1:0];
    if (w_shr > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_shr < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end
  end

  // Registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      r_s_ready <= (w_state_nxt == ST_IDLE);
      if (w_load_out) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_sat;
      end else if (w_out_done) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign o_s_ready = r_s_ready;
  assign o_m_valid = r_m_valid;
  assign o_m_data  = r_m_data;

endmodule

// File: tb/tb_mf_fir_serial.sv
// Directed bench for mf_fir_serial: impulse, DC, saturation, latency,
// backpressure and mid-operation reset against a direct-convolution model.
module tb_mf_fir_serial;

  localparam int NT = 41;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               m_ready;
  logic               s_ready, m_valid;
  logic signed [15:0] m_data;
  logic               s_ready_q, m_valid_q;
  logic signed [15:0] m_data_q;

  mf_fir_serial u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_s_data  (s_data),
    .i_s_valid (s_valid),
    .o_s_ready (s_ready),
    .o_m_data  (m_data),
    .o_m_valid (m_valid),
    .i_m_ready (m_ready)
  );

  mf_fir_serial #(.OUT_SHIFT(14)) u_dut_sat (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_s_data  (s_data),
    .i_s_valid (s_valid),
    .o_s_ready (s_ready_q),
    .o_m_data  (m_data_q),
    .o_m_valid (m_valid_q),
    .i_m_ready (m_ready)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  int     h [NT];
  longint hist [NT];
  longint imp_ref [46];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input int shift);
    longint acc;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(h[k]) * hist[k];
    acc = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic push(input longint x);
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endtask

  task automatic clear_hist();
    for (int k = 0; k < NT; k++) hist[k] = 0;
  endtask

  // One full transaction with m_ready high; returns both instances' outputs
  task automatic xfer(input logic signed [15:0] x, input string tag,
                      output longint y, output longint ys);
    bit ok;
    @(negedge clk);
    s_data  = x;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (s_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check({tag, "_accept_timeout"}, 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
    push(longint'(x));
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check({tag, "_valid_timeout"}, 0, 1);
    y  = longint'(m_data);
    ys = longint'(m_data_q);
    check(tag, y, model(20));
    check({tag, "_sat"}, ys, model(14));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint y, ys, hold;
    int     bad, first, c;

    for (int k = 0; k < NT; k++)
      h[k] = $rtoi(32767.0 * $sin(3.14159265358979 * k / 40.0) + 0.5);
    clear_hist();

    rst = 1'b1; s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sready", s_ready, 1);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_mdata_sat", m_data_q, 0);
    rst = 1'b0;

    // Impulse response
    for (int i = 0; i < 46; i++) begin
      xfer((i == 0) ? 16'sd32767 : 16'sd0, $sformatf("imp%0d", i), y, ys);
      imp_ref[i] = y;
    end
    check("imp_y0", imp_ref[0], 0);
    check("imp_y1", imp_ref[1], 80);
    check("imp_y20", imp_ref[20], 1024);
    check("imp_y40", imp_ref[40], 0);
    check("imp_y45", imp_ref[45], 0);

    // DC positive and negative full scale
    for (int i = 0; i < 50; i++) begin
      xfer(16'sd32767, $sformatf("dcp%0d", i), y, ys);
      if (i >= 40) begin
        check($sformatf("dcp_const%0d", i), y, 26061);
        check($sformatf("dcp_satc%0d", i), ys, 32767);
      end
    end
    for (int i = 0; i < 50; i++) begin
      xfer(-16'sd32768, $sformatf("dcn%0d", i), y, ys);
      if (i >= 40) begin
        check($sformatf("dcn_const%0d", i), y, -26062);
        check($sformatf("dcn_satc%0d", i), ys, -32768);
      end
    end

    // Latency: single input, s_valid held high with the next sample
    @(negedge clk);
    s_data = 16'sd1000; s_valid = 1'b1;
    check("lat_sready_c0", s_ready, 1);
    @(negedge clk);
    push(1000);
    s_data = -16'sd2000;
    bad = 0; first = -1; y = 0;
    for (int cc = 1; cc <= 44; cc++) begin
      if (s_ready) bad++;
      if (m_valid && first < 0) first = cc;
      if (cc == 44) y = longint'(m_data);
      @(negedge clk);
    end
    check("lat_sready_busy", bad, 0);
    check("lat_mvalid_cycle", first, 44);
    check("lat_data", y, model(20));
    check("lat_sready_c45", s_ready, 1);
    check("lat_mvalid_c45", m_valid, 0);
    @(negedge clk);
    s_valid = 1'b0;
    push(-2000);
    c = 1;
    while (!m_valid && c < 200) begin @(negedge clk); c++; end
    check("lat2_cycle", c, 44);
    check("lat2_data", m_data, model(20));
    check("lat2_data_sat", m_data_q, model(14));
    @(negedge clk);

    // Backpressure in OUT
    m_ready = 1'b0;
    s_data = 16'sd12345; s_valid = 1'b1;
    check("bp_sready_idle", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    push(12345);
    c = 0;
    while (!m_valid && c < 200) begin @(negedge clk); c++; end
    check("bp_valid_seen", m_valid, 1);
    hold = longint'(m_data);
    check("bp_data", hold, model(20));
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (longint'(m_data) != hold || !m_valid || s_ready) bad++;
    end
    check("bp_stable", bad, 0);
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_mvalid_after", m_valid, 0);
    check("bp_sready_after", s_ready, 1);

    // Reset in the middle of MAC
    s_data = 16'sd32767; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_mdata", m_data, 0);
    check("mrst_sready", s_ready, 1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_valid || m_valid_q || !s_ready) bad++;
      @(negedge clk);
    end
    check("mrst_no_valid", bad, 0);
    clear_hist();
    for (int i = 0; i < 87; i++) begin
      xfer((i == 0) ? 16'sd32767 : 16'sd0, $sformatf("rimp%0d", i), y, ys);
      if (i < 46) check($sformatf("rimp_repro%0d", i), y, imp_ref[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
